// File: rtl/pixfifo_pkg.sv
// pixfifo_pkg: shared types and defaults for the pixel FIFO write side.
package pixfifo_pkg;
  typedef enum logic [1:0] {IDLE, BURST, CLEAR} state_t;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_CLEAR_CYCLES = 2;
  localparam logic SRC_IMG = 1'b0;
  localparam logic SRC_OVL = 1'b1;
endpackage

// File: rtl/fifo_wr_scheduler_if.sv
// fifo_wr_scheduler_if: source handshake and FIFO write-port bundle.
interface fifo_wr_scheduler_if #(parameter int DATA_WIDTH = pixfifo_pkg::DEF_DATA_WIDTH);
  logic                  frame_start;
  logic [1:0]            src_req;
  logic [1:0]            src_valid;
  logic [DATA_WIDTH-1:0] src_data0;
  logic [DATA_WIDTH-1:0] src_data1;
  logic [1:0]            src_gnt;
  logic [1:0]            src_ack;
  logic                  fifo_full;
  logic                  fifo_wren;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  fifo_clear;
  logic                  burst_done;
  modport master (
    input  frame_start, src_req, src_valid, src_data0, src_data1, fifo_full,
    output src_gnt, src_ack, fifo_wren, fifo_din, fifo_clear, burst_done
  );
  modport slave (
    output frame_start, src_req, src_valid, src_data0, src_data1, fifo_full,
    input  src_gnt, src_ack, fifo_wren, fifo_din, fifo_clear, burst_done
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on contention the previous loser wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] winner
);
  assign winner = &req ? (last_winner ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/fifo_wr_scheduler.sv
// fifo_wr_scheduler: burst-granted sharing of the pixel FIFO write port with frame-start clear sequencing.
module fifo_wr_scheduler
  import pixfifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input logic clk_wr,
  input logic rst_n,
  fifo_wr_scheduler_if.master bus
);
  localparam int CW = $clog2(BURST_LEN);
  localparam int KW = $clog2(CLEAR_CYCLES + 1);
  state_t state, state_nxt;
  logic [1:0] gnt, gnt_nxt, win;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [KW-1:0] clr_cnt, clr_cnt_nxt;
  logic last, last_nxt, done, done_nxt;
  logic s, wr, fin;
  logic [DATA_WIDTH-1:0] sel_data;
  rr_arbiter2 u_arb (.req(bus.src_req), .last_winner(last), .winner(win));
  assign s = gnt[SRC_OVL];
  // frame_start pre-empts any write in the same cycle
  assign wr = (state == BURST) & bus.src_valid[s] & ~bus.fifo_full & ~bus.frame_start;
  assign fin = wr ? cnt == CW'(BURST_LEN - 1) : ~bus.src_req[s];
  assign sel_data = s ? bus.src_data1 : bus.src_data0;
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    cnt_nxt     = cnt;
    clr_cnt_nxt = clr_cnt;
    last_nxt    = last;
    done_nxt    = 1'b0;
    if (bus.frame_start) begin
      state_nxt   = CLEAR;
      gnt_nxt     = 2'b00;
      cnt_nxt     = '0;
      clr_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: if (|bus.src_req) begin
          state_nxt = BURST;
          gnt_nxt   = win;
          cnt_nxt   = '0;
        end
        BURST: begin
          cnt_nxt = cnt + CW'(wr);
          if (fin) begin
            state_nxt = IDLE;
            gnt_nxt   = 2'b00;
            cnt_nxt   = '0;
            last_nxt  = s;
            done_nxt  = 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_nxt = clr_cnt + KW'(1);
          if (clr_cnt == KW'(CLEAR_CYCLES - 1)) begin
            state_nxt   = IDLE;
            clr_cnt_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      cnt     <= '0;
      clr_cnt <= '0;
      last    <= SRC_OVL;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      cnt     <= cnt_nxt;
      clr_cnt <= clr_cnt_nxt;
      last    <= last_nxt;
      done    <= done_nxt;
    end
  end
  assign bus.src_gnt    = gnt;
  assign bus.src_ack    = wr ? gnt : 2'b00;
  assign bus.fifo_wren  = wr;
  assign bus.fifo_din   = |gnt ? sel_data : '0;
  assign bus.fifo_clear = state == CLEAR;
  assign bus.burst_done = done;
endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// tb_fifo_wr_scheduler: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_fifo_wr_scheduler;
  typedef struct {
    logic        s;
    logic [11:0] d;
  } item_t;
  logic clk_wr = 1'b0;
  logic rst_n;
  fifo_wr_scheduler_if #(.DATA_WIDTH(12)) bus ();
  fifo_wr_scheduler #(.DATA_WIDTH(12), .BURST_LEN(4), .CLEAR_CYCLES(2)) dut (
    .clk_wr(clk_wr),
    .rst_n(rst_n),
    .bus(bus.master)
  );
  always #5 clk_wr = ~clk_wr;
  item_t wq[$];
  int bq[$];
  int cq[$];
  item_t mon_it;
  int n_chk = 0, n_fail = 0;
  int e0 = 0, e1 = 0;
  int wcount = 0, clen = 0;
  logic [11:0] p0 = 12'h0, p1 = 12'h0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_words(input logic s, input int n);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.s = s;
      it.d = s ? 12'h200 + 12'(e1) : 12'h100 + 12'(e0);
      wq.push_back(it);
      if (s) e1++;
      else e0++;
    end
  endtask

  // sources pop a word on every acked cycle
  task automatic tick();
    logic [1:0] a;
    @(negedge clk_wr);
    a = bus.src_ack;
    @(posedge clk_wr);
    #1;
    if (a[0]) p0++;
    if (a[1]) p1++;
    bus.src_data0 = 12'h100 + p0;
    bus.src_data1 = 12'h200 + p1;
  endtask

  always @(negedge clk_wr) begin
    if (bus.fifo_wren) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got din %0h expected no write at %0t", bus.fifo_din, $time);
      end else begin
        mon_it = wq.pop_front();
        chk("din", bus.fifo_din, mon_it.d);
        chk("ack", 12'(bus.src_ack), mon_it.s ? 12'h2 : 12'h1);
        chk("gnt_wr", 12'(bus.src_gnt), mon_it.s ? 12'h2 : 12'h1);
      end
      wcount++;
    end else chk("ack_idle", 12'(bus.src_ack), 12'h0);
    if (bus.burst_done) begin
      if (bq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got burst_done 1 expected 0 at %0t", $time);
      end else chk("burst_words", 12'(wcount), 12'(bq.pop_front()));
      wcount = 0;
    end
    if (bus.fifo_clear || !rst_n) wcount = 0;
    if (bus.fifo_clear) clen++;
    else if (clen != 0) begin
      if (cq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_clear: got %0d clear cycles expected 0", clen);
      end else chk("clear_len", 12'(clen), 12'(cq.pop_front()));
      clen = 0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 12'(bus.src_gnt), 12'h0);
    chk({tag, "_ack"}, 12'(bus.src_ack), 12'h0);
    chk({tag, "_wren"}, 12'(bus.fifo_wren), 12'h0);
    chk({tag, "_clear"}, 12'(bus.fifo_clear), 12'h0);
    chk({tag, "_done"}, 12'(bus.burst_done), 12'h0);
    chk({tag, "_din"}, bus.fifo_din, 12'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.src_req = 2'b00;
    bus.src_valid = 2'b00;
    bus.fifo_full = 1'b0;
    bus.src_data0 = 12'h100;
    bus.src_data1 = 12'h200;
    tick();
    tick();
    #1 chk_reset_outputs("rst");
    rst_n = 1'b1;
    // single source burst from reset
    bus.src_req = 2'b01;
    bus.src_valid = 2'b11;
    exp_words(1'b0, 4);
    bq.push_back(4);
    tick();
    chk("t1_gnt", 12'(bus.src_gnt), 12'h1);
    bus.src_req = 2'b00;
    #1 chk("t1_wren_c1", 12'(bus.fifo_wren), 12'h1);
    chk("t1_din_c1", bus.fifo_din, 12'h100);
    repeat (4) tick();
    #1 chk("t1_done_c5", 12'(bus.burst_done), 12'h1);
    chk("t1_gnt_c5", 12'(bus.src_gnt), 12'h0);
    tick();
    chk("t1_done_c6", 12'(bus.burst_done), 12'h0);
    // contention alternates, fresh priority
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.src_req = 2'b11;
    exp_words(1'b0, 4);
    bq.push_back(4);
    exp_words(1'b1, 4);
    bq.push_back(4);
    exp_words(1'b0, 4);
    bq.push_back(4);
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) chk("t2_gnt_c1", 12'(bus.src_gnt), 12'h1);
      if (i == 5) chk("t2_gnt_idle", 12'(bus.src_gnt), 12'h0);
      if (i == 6) chk("t2_gnt_c6", 12'(bus.src_gnt), 12'h2);
      if (i == 11) begin
        chk("t2_gnt_c11", 12'(bus.src_gnt), 12'h1);
        bus.src_req = 2'b00;
      end
    end
    tick();
    tick();
    // stall on full after two words
    bus.src_req = 2'b01;
    exp_words(1'b0, 4);
    bq.push_back(4);
    tick();
    tick();
    tick();
    bus.fifo_full = 1'b1;
    #1 chk("t3_wren_stall", 12'(bus.fifo_wren), 12'h0);
    chk("t3_ack_stall", 12'(bus.src_ack), 12'h0);
    tick();
    tick();
    #1 chk("t3_wren_stall3", 12'(bus.fifo_wren), 12'h0);
    chk("t3_gnt_stall3", 12'(bus.src_gnt), 12'h1);
    tick();
    bus.fifo_full = 1'b0;
    #1 chk("t3_wren_resume", 12'(bus.fifo_wren), 12'h1);
    tick();
    bus.src_req = 2'b00;
    tick();
    #1 chk("t3_done", 12'(bus.burst_done), 12'h1);
    tick();
    // early termination, then full burst proves the count restarted
    bus.src_req = 2'b01;
    bus.src_valid = 2'b01;
    exp_words(1'b0, 2);
    bq.push_back(2);
    tick();
    tick();
    tick();
    bus.src_req = 2'b00;
    bus.src_valid = 2'b00;
    tick();
    #1 chk("t4_done", 12'(bus.burst_done), 12'h1);
    chk("t4_gnt", 12'(bus.src_gnt), 12'h0);
    tick();
    bus.src_req = 2'b01;
    bus.src_valid = 2'b01;
    exp_words(1'b0, 4);
    bq.push_back(4);
    tick();
    chk("t4_regnt", 12'(bus.src_gnt), 12'h1);
    bus.src_req = 2'b00;
    repeat (4) tick();
    #1 chk("t4_done2", 12'(bus.burst_done), 12'h1);
    tick();
    // frame_start on third word aborts without burst_done
    bus.src_req = 2'b11;
    bus.src_valid = 2'b11;
    exp_words(1'b1, 2);
    cq.push_back(2);
    tick();
    chk("t5_gnt", 12'(bus.src_gnt), 12'h2);
    tick();
    tick();
    bus.frame_start = 1'b1;
    #1 chk("t5_wren_abort", 12'(bus.fifo_wren), 12'h0);
    tick();
    bus.frame_start = 1'b0;
    #1 chk("t5_clear_c4", 12'(bus.fifo_clear), 12'h1);
    chk("t5_gnt_c4", 12'(bus.src_gnt), 12'h0);
    chk("t5_done_c4", 12'(bus.burst_done), 12'h0);
    tick();
    chk("t5_clear_c5", 12'(bus.fifo_clear), 12'h1);
    tick();
    chk("t5_clear_c6", 12'(bus.fifo_clear), 12'h0);
    chk("t5_gnt_c6", 12'(bus.src_gnt), 12'h0);
    exp_words(1'b1, 4);
    bq.push_back(4);
    tick();
    chk("t5_gnt_c7", 12'(bus.src_gnt), 12'h2);
    bus.src_req = 2'b00;
    repeat (4) tick();
    #1 chk("t5_done", 12'(bus.burst_done), 12'h1);
    tick();
    // frame_start during CLEAR restarts the count
    bus.frame_start = 1'b1;
    cq.push_back(3);
    tick();
    tick();
    bus.frame_start = 1'b0;
    tick();
    chk("clr_restart_c3", 12'(bus.fifo_clear), 12'h1);
    tick();
    chk("clr_restart_c4", 12'(bus.fifo_clear), 12'h0);
    // make source 0 the last winner, then reset mid-burst
    bus.src_req = 2'b01;
    exp_words(1'b0, 4);
    bq.push_back(4);
    tick();
    bus.src_req = 2'b00;
    repeat (4) tick();
    tick();
    bus.src_req = 2'b01;
    exp_words(1'b0, 2);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    bus.src_valid = 2'b00;
    tick();
    #1 chk_reset_outputs("mid_rst");
    rst_n = 1'b1;
    bus.src_req = 2'b11;
    bus.src_valid = 2'b11;
    exp_words(1'b0, 4);
    bq.push_back(4);
    tick();
    chk("t6_gnt_after_rst", 12'(bus.src_gnt), 12'h1);
    bus.src_req = 2'b00;
    repeat (4) tick();
    tick();
    tick();
    #1;
    chk("wq_empty", 12'(wq.size()), 12'h0);
    chk("bq_empty", 12'(bq.size()), 12'h0);
    chk("cq_empty", 12'(cq.size()), 12'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
